// File: rtl/tpu_ctrl_pkg.sv
// Shared types and constants for the TPU tile sequencer and its result-write scheduler.
package tpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWfetch,
    StWload,
    StFeed,
    StFlush,
    StDone
  } seq_state_e;

  typedef enum logic [1:0] {
    SchIdle,
    SchWait,
    SchWrite
  } sched_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned AddrSizeDflt   = 10;
  localparam int unsigned MatrixSizeDflt = 16;
  localparam int unsigned OutLatDflt     = 34;
  localparam int unsigned FeedCntW       = cnt_w(MatrixSizeDflt);
  localparam int unsigned LatCntW        = 8;

endpackage

// File: rtl/tpu_res_sched.sv
// Result-write window scheduler: armed on the first feed cycle, waits OUT_LAT cycles, then
// emits MATRIX_SIZE consecutive result writes and flags the last one with window_done.
module tpu_res_sched
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESSSIZE = AddrSizeDflt,
  parameter int unsigned MATRIX_SIZE = MatrixSizeDflt,
  parameter int unsigned OUT_LAT     = OutLatDflt
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   abort,
  input  logic                   arm,
  input  logic [ADDRESSSIZE-1:0] res_base,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   window_done
);

  localparam int unsigned CntW = cnt_w(MATRIX_SIZE);
  localparam logic [CntW-1:0]        WinLast = CntW'(MATRIX_SIZE - 1);
  localparam logic [CntW-1:0]        CntOne  = CntW'(1);
  localparam logic [LatCntW-1:0]     LatInit = LatCntW'(OUT_LAT - 1);
  localparam logic [LatCntW-1:0]     LatOne  = LatCntW'(1);
  localparam logic [ADDRESSSIZE-1:0] AddrOne = ADDRESSSIZE'(1);

  sched_state_e        st_q, st_d;
  logic [LatCntW-1:0]  lat_q, lat_d;
  logic [CntW-1:0]     wcnt_q, wcnt_d;

  always_comb begin
    st_d   = st_q;
    lat_d  = lat_q;
    wcnt_d = wcnt_q;
    unique case (st_q)
      SchIdle: begin
        if (arm) begin
          lat_d  = LatInit;
          wcnt_d = '0;
          st_d   = (LatInit == '0) ? SchWrite : SchWait;
        end
      end
      SchWait: begin
        lat_d = lat_q - LatOne;
        if (lat_q == LatOne) st_d = SchWrite;
      end
      SchWrite: begin
        if (wcnt_q == WinLast) st_d = SchIdle;
        else wcnt_d = wcnt_q + CntOne;
      end
      default: st_d = SchIdle;
    endcase
  end

  assign window_done = (st_q == SchWrite) && (wcnt_q == WinLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= SchIdle;
      lat_q       <= '0;
      wcnt_q      <= '0;
      res_we      <= 1'b0;
      res_address <= '0;
    end else if (abort) begin
      // Cancel the window; the address output keeps its last value.
      st_q   <= SchIdle;
      res_we <= 1'b0;
    end else begin
      st_q   <= st_d;
      lat_q  <= lat_d;
      wcnt_q <= wcnt_d;
      res_we <= (st_d == SchWrite);
      if (st_d == SchWrite) begin
        res_address <= (st_q != SchWrite) ? res_base : res_address + AddrOne;
      end
    end
  end

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Tile sequencer for the systolic TPU: weight pop/load, activation feed, result-write scheduling.
// Optional busy-cycle performance counter enabled by TPU_SEQ_CTRL_PERF_EN.
module tpu_seq_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESSSIZE = AddrSizeDflt,
  parameter int unsigned MATRIX_SIZE = MatrixSizeDflt,
  parameter int unsigned OUT_LAT     = OutLatDflt
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   fifo_empty,
  input  logic [ADDRESSSIZE-1:0] act_base,
  input  logic [ADDRESSSIZE-1:0] res_base,
  output logic                   busy,
  output logic                   end_,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic                   valid_address,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   err_empty,
  output logic [31:0]            busy_cycles
);

  localparam int unsigned CntW = cnt_w(MATRIX_SIZE);
  localparam logic [CntW-1:0]        FeedLast = CntW'(MATRIX_SIZE - 1);
  localparam logic [CntW-1:0]        CntOne   = CntW'(1);
  localparam logic [ADDRESSSIZE-1:0] AddrOne  = ADDRESSSIZE'(1);

  seq_state_e              state_q, state_d;
  logic [CntW-1:0]         feed_cnt_q, feed_cnt_d;
  logic [ADDRESSSIZE-1:0]  act_base_q, res_base_q;
  logic                    arm_q;
  logic                    accept;
  logic                    window_done;

  assign accept = (state_q == StIdle) && start && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    feed_cnt_d = feed_cnt_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StWfetch;
      StWfetch: state_d = StWload;
      StWload: begin
        state_d    = StFeed;
        feed_cnt_d = '0;
      end
      StFeed: begin
        if (feed_cnt_q == FeedLast) state_d = StFlush;
        else feed_cnt_d = feed_cnt_q + CntOne;
      end
      StFlush:  if (window_done) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      feed_cnt_q       <= '0;
      act_base_q       <= '0;
      res_base_q       <= '0;
      arm_q            <= 1'b0;
      busy             <= 1'b0;
      end_             <= 1'b0;
      fifo_read_enable <= 1'b0;
      we_rl            <= 1'b0;
      valid_address    <= 1'b0;
      sram_address     <= '0;
      err_empty        <= 1'b0;
    end else begin
      state_q    <= state_d;
      feed_cnt_q <= feed_cnt_d;
      if (accept) begin
        act_base_q <= act_base;
        res_base_q <= res_base;
      end
      // Outputs are registered copies of the next-state decode.
      arm_q            <= (state_q == StWload) && (state_d == StFeed);
      busy             <= (state_d != StIdle);
      end_             <= (state_d == StDone);
      fifo_read_enable <= (state_d == StWfetch);
      we_rl            <= (state_d == StWload);
      valid_address    <= (state_d == StFeed);
      if (state_d == StFeed) begin
        sram_address <= (state_q == StWload) ? act_base_q : sram_address + AddrOne;
      end
      err_empty <= (state_q == StIdle) && start && fifo_empty;
    end
  end

  tpu_res_sched #(
    .ADDRESSSIZE (ADDRESSSIZE),
    .MATRIX_SIZE (MATRIX_SIZE),
    .OUT_LAT     (OUT_LAT)
  ) u_res_sched (
    .clk         (clk),
    .rst         (rst),
    .abort       (abort),
    .arm         (arm_q),
    .res_base    (res_base_q),
    .res_we      (res_we),
    .res_address (res_address),
    .window_done (window_done)
  );

`ifdef TPU_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cycles <= '0;
    end else if (accept) begin
      busy_cycles <= 32'd1;
    end else if ((state_d != StIdle) && (busy_cycles != '1)) begin
      busy_cycles <= busy_cycles + 32'd1;
    end
  end
`else
  assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Bench for tpu_seq_ctrl: two instances (OUT_LAT 34 and 4) driven in lockstep and checked
// every cycle against a cycle-offset model of one tile; directed cases then random traffic.
module tb_tpu_seq_ctrl;

  localparam int unsigned Ms = 16;
`ifdef TPU_SEQ_CTRL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       fifo_empty;
  logic [9:0] act_base;
  logic [9:0] res_base;

  logic [1:0] busy_w, end_w, fre_w, werl_w, valid_w, reswe_w, err_w;
  logic [9:0] sram_w [2];
  logic [9:0] resa_w [2];
  logic [31:0] perf_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one entry per instance.
  int          lat    [2] = '{34, 4};
  bit          m_act  [2];
  int          m_t    [2];
  int          m_abase[2];
  int          m_rbase[2];
  logic [9:0]  m_sram [2];
  logic [9:0]  m_resa [2];
  int          m_perf [2];
  bit          m_err  [2];

  tpu_seq_ctrl #(
    .ADDRESSSIZE (10),
    .MATRIX_SIZE (Ms),
    .OUT_LAT     (34)
  ) dut0 (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .fifo_empty       (fifo_empty),
    .act_base         (act_base),
    .res_base         (res_base),
    .busy             (busy_w[0]),
    .end_             (end_w[0]),
    .fifo_read_enable (fre_w[0]),
    .we_rl            (werl_w[0]),
    .valid_address    (valid_w[0]),
    .sram_address     (sram_w[0]),
    .res_we           (reswe_w[0]),
    .res_address      (resa_w[0]),
    .err_empty        (err_w[0]),
    .busy_cycles      (perf_w[0])
  );

  tpu_seq_ctrl #(
    .ADDRESSSIZE (10),
    .MATRIX_SIZE (Ms),
    .OUT_LAT     (4)
  ) dut1 (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .fifo_empty       (fifo_empty),
    .act_base         (act_base),
    .res_base         (res_base),
    .busy             (busy_w[1]),
    .end_             (end_w[1]),
    .fifo_read_enable (fre_w[1]),
    .we_rl            (werl_w[1]),
    .valid_address    (valid_w[1]),
    .sram_address     (sram_w[1]),
    .res_we           (reswe_w[1]),
    .res_address      (resa_w[1]),
    .err_empty        (err_w[1]),
    .busy_cycles      (perf_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs the DUT samples there.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int end_cyc;
      end_cyc = 3 + lat[i] + Ms;
      if (rst) begin
        m_act[i]  = 1'b0;
        m_t[i]    = 0;
        m_sram[i] = '0;
        m_resa[i] = '0;
        m_perf[i] = 0;
        m_err[i]  = 1'b0;
      end else begin
        m_err[i] = !m_act[i] && start && fifo_empty;
        if (!m_act[i]) begin
          if (start && !fifo_empty) begin
            m_act[i]   = 1'b1;
            m_t[i]     = 1;
            m_abase[i] = int'(act_base);
            m_rbase[i] = int'(res_base);
          end
        end else if (abort || m_t[i] == end_cyc) begin
          m_act[i] = 1'b0;
        end else begin
          m_t[i]++;
        end
        if (m_act[i]) begin
          m_perf[i] = m_t[i];
          if (m_t[i] >= 3 && m_t[i] <= 2 + Ms)
            m_sram[i] = 10'((m_abase[i] + m_t[i] - 3) % 1024);
          if (m_t[i] >= 3 + lat[i] && m_t[i] <= 2 + lat[i] + Ms)
            m_resa[i] = 10'((m_rbase[i] + m_t[i] - 3 - lat[i]) % 1024);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int  t;
      bit  a;
      t = m_t[i];
      a = m_act[i];
      check_eq($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(a));
      check_eq($sformatf("fifo_read_enable[%0d]", i), 32'(fre_w[i]), 32'(a && t == 1));
      check_eq($sformatf("we_rl[%0d]", i), 32'(werl_w[i]), 32'(a && t == 2));
      check_eq($sformatf("valid_address[%0d]", i), 32'(valid_w[i]),
               32'(a && t >= 3 && t <= 2 + Ms));
      check_eq($sformatf("sram_address[%0d]", i), 32'(sram_w[i]), 32'(m_sram[i]));
      check_eq($sformatf("res_we[%0d]", i), 32'(reswe_w[i]),
               32'(a && t >= 3 + lat[i] && t <= 2 + lat[i] + Ms));
      check_eq($sformatf("res_address[%0d]", i), 32'(resa_w[i]), 32'(m_resa[i]));
      check_eq($sformatf("end_[%0d]", i), 32'(end_w[i]), 32'(a && t == 3 + lat[i] + Ms));
      check_eq($sformatf("err_empty[%0d]", i), 32'(err_w[i]), 32'(m_err[i]));
      check_eq($sformatf("busy_cycles[%0d]", i), perf_w[i], PerfEn ? 32'(m_perf[i]) : 32'd0);
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic fe,
                      input logic [9:0] abase, input logic [9:0] rbase, input logic r);
    @(negedge clk);
    start      = st;
    abort      = ab;
    fifo_empty = fe;
    act_base   = abase;
    res_base   = rbase;
    rst        = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    fifo_empty = 1'b0;
    act_base   = '0;
    res_base   = '0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_abase[i] = 0; m_rbase[i] = 0;
      m_sram[i] = '0; m_resa[i] = '0; m_perf[i] = 0; m_err[i] = 1'b0;
    end

    // Reset state.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
    idle(2);

    // Nominal tile from base 0, then quiet cycles to watch the counter hold.
    step(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
    idle(60);

    // Start refused on an empty weight FIFO.
    step(1'b1, 1'b0, 1'b1, 10'd3, 10'd4, 1'b0);
    idle(4);

    // Address wrap on both SRAMs.
    step(1'b1, 1'b0, 1'b0, 10'd1020, 10'd1015, 1'b0);
    idle(60);

    // Abort at cycle 10, restart at cycle 12.
    step(1'b1, 1'b0, 1'b0, 10'd100, 10'd200, 1'b0);
    idle(9);
    step(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 10'd50, 10'd60, 1'b0);
    idle(60);

    // Start and abort together while idle: the start wins.
    step(1'b1, 1'b1, 1'b0, 10'd5, 10'd7, 1'b0);
    idle(60);

    // Reset in the middle of a tile.
    step(1'b1, 1'b0, 1'b0, 10'd9, 10'd9, 1'b0);
    idle(20);
    step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
    idle(3);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0), 10'($urandom), 10'($urandom),
           ($urandom_range(0, 299) == 0));
    end
    idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
